// File: rtl/lif_pkg.sv
// rtl/lif_pkg.sv - shared types and default constants for the LIF neuron
package lif_pkg;

  typedef enum logic {
    INTEGRATE  = 1'b0,
    REFRACTORY = 1'b1
  } lif_state_e;

  localparam int DEF_WIDTH       = 8;
  localparam int DEF_THRESHOLD   = 64;
  localparam int DEF_EXC_WEIGHT  = 16;
  localparam int DEF_INH_WEIGHT  = 8;
  localparam int DEF_LEAK_PERIOD = 16;
  localparam int DEF_LEAK_SHIFT  = 3;
  localparam int DEF_REFRACT     = 4;

  localparam int SPK_CNT_W = 8;

endpackage

// File: rtl/lif_leak_timer.sv
// rtl/lif_leak_timer.sv - modulo LEAK_PERIOD counter producing the leak tick
module lif_leak_timer
  import lif_pkg::*;
#(
  parameter int LEAK_PERIOD = DEF_LEAK_PERIOD
) (
  input  logic clk,
  input  logic reset_i,
  input  logic en_i,
  input  logic clear_i,
  output logic leak_tick_o
);

  localparam int CW = $clog2(LEAK_PERIOD);
  localparam logic [CW-1:0] LAST = CW'(LEAK_PERIOD - 1);

  logic [CW-1:0] r_cnt;

  assign leak_tick_o = (r_cnt == LAST);

  // Count enabled cycles, wrapping on the tick; clear wins over counting.
  always_ff @(posedge clk) begin
    if (!reset_i) begin
      r_cnt <= '0;
    end else if (clear_i) begin
      r_cnt <= '0;
    end else if (en_i) begin
      r_cnt <= leak_tick_o ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/lif_neuron.sv
// rtl/lif_neuron.sv - leaky integrate-and-fire neuron with refractory hold-off
module lif_neuron
  import lif_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int THRESHOLD   = DEF_THRESHOLD,
  parameter int EXC_WEIGHT  = DEF_EXC_WEIGHT,
  parameter int INH_WEIGHT  = DEF_INH_WEIGHT,
  parameter int LEAK_PERIOD = DEF_LEAK_PERIOD,
  parameter int LEAK_SHIFT  = DEF_LEAK_SHIFT,
  parameter int REFRACT     = DEF_REFRACT
) (
  input  logic                 clk,
  input  logic                 reset_i,
  input  logic                 en_i,
  input  logic                 excite_i,
  input  logic                 inhibit_i,
  output logic                 spike_o,
  output logic                 refractory_o,
  output logic [WIDTH-1:0]     membrane_o,
  output logic [SPK_CNT_W-1:0] spike_count_o
);

  localparam int SW = WIDTH + 2;
  localparam int RW = $clog2(REFRACT + 1);
  localparam logic [WIDTH-1:0]     THR      = WIDTH'(THRESHOLD);
  localparam logic signed [SW-1:0] EXC_S    = SW'(EXC_WEIGHT);
  localparam logic signed [SW-1:0] INH_S    = SW'(INH_WEIGHT);
  localparam logic signed [SW-1:0] VMAX_S   = SW'((1 << WIDTH) - 1);
  localparam logic [RW-1:0]        REF_LOAD = RW'(REFRACT - 1);

  lif_state_e           r_state;
  logic                 r_spike;
  logic                 r_refr;
  logic [WIDTH-1:0]     r_mem;
  logic [SPK_CNT_W-1:0] r_count;
  logic [RW-1:0]        r_ref_cnt;

  logic                 w_leak_tick;
  logic                 w_timer_en;
  logic                 w_timer_clr;
  logic [WIDTH-1:0]     w_shifted;
  logic [WIDTH-1:0]     w_leak;
  logic [WIDTH-1:0]     w_v1;
  logic signed [SW-1:0] w_sum;
  logic [WIDTH-1:0]     w_v2;
  logic                 w_fire;

  assign w_timer_en  = en_i && (r_state == INTEGRATE);
  assign w_timer_clr = en_i && ((r_state == REFRACTORY) || w_fire);

  lif_leak_timer #(
    .LEAK_PERIOD(LEAK_PERIOD)
  ) u_leak_timer (
    .clk        (clk),
    .reset_i    (reset_i),
    .en_i       (w_timer_en),
    .clear_i    (w_timer_clr),
    .leak_tick_o(w_leak_tick)
  );

  // Candidate potential: leak first, then net synaptic input, clamped to the unsigned range.
  always_comb begin
    w_shifted = r_mem >> LEAK_SHIFT;
    if (r_mem == '0) begin
      w_leak = '0;
    end else if (w_shifted == '0) begin
      w_leak = WIDTH'(1);
    end else begin
      w_leak = w_shifted;
    end
    w_v1  = w_leak_tick ? (r_mem - w_leak) : r_mem;
    w_sum = $signed({2'b00, w_v1});
    if (excite_i) begin
      w_sum = w_sum + EXC_S;
    end
    if (inhibit_i) begin
      w_sum = w_sum - INH_S;
    end
    if (w_sum[SW-1]) begin
      w_v2 = '0;
    end else if (w_sum > VMAX_S) begin
      w_v2 = '1;
    end else begin
      w_v2 = w_sum[WIDTH-1:0];
    end
    w_fire = (w_v2 >= THR);
  end

  // Integrate/fire FSM with refractory down-counter; en_i low freezes everything but the spike flag.
  always_ff @(posedge clk) begin
    if (!reset_i) begin
      r_state   <= INTEGRATE;
      r_spike   <= 1'b0;
      r_refr    <= 1'b0;
      r_mem     <= '0;
      r_count   <= '0;
      r_ref_cnt <= '0;
    end else if (!en_i) begin
      r_spike <= 1'b0;
    end else if (r_state == INTEGRATE) begin
      if (w_fire) begin
        r_state   <= REFRACTORY;
        r_mem     <= '0;
        r_spike   <= 1'b1;
        r_refr    <= 1'b1;
        r_ref_cnt <= REF_LOAD;
        if (r_count != '1) begin
          r_count <= r_count + 1'b1;
        end
      end else begin
        r_mem   <= w_v2;
        r_spike <= 1'b0;
      end
    end else begin
      r_mem   <= '0;
      r_spike <= 1'b0;
      if (r_ref_cnt == '0) begin
        r_state <= INTEGRATE;
        r_refr  <= 1'b0;
      end else begin
        r_ref_cnt <= r_ref_cnt - 1'b1;
      end
    end
  end

  assign spike_o       = r_spike;
  assign refractory_o  = r_refr;
  assign membrane_o    = r_mem;
  assign spike_count_o = r_count;

endmodule

// File: tb/tb_lif_neuron.sv
// tb/tb_lif_neuron.sv - randomized and directed checks of lif_neuron against a reference model
module tb_lif_neuron;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_i   = 1'b0;
  logic       en_i      = 1'b1;
  logic       excite_i  = 1'b0;
  logic       inhibit_i = 1'b0;

  logic       spk_a, refr_a, spk_b, refr_b;
  logic [7:0] mem_a, cnt_a, mem_b, cnt_b;

  lif_neuron #(.THRESHOLD(64)) u_dut_a (
    .clk          (clk),
    .reset_i      (reset_i),
    .en_i         (en_i),
    .excite_i     (excite_i),
    .inhibit_i    (inhibit_i),
    .spike_o      (spk_a),
    .refractory_o (refr_a),
    .membrane_o   (mem_a),
    .spike_count_o(cnt_a)
  );

  lif_neuron #(.THRESHOLD(255)) u_dut_b (
    .clk          (clk),
    .reset_i      (reset_i),
    .en_i         (en_i),
    .excite_i     (excite_i),
    .inhibit_i    (inhibit_i),
    .spike_o      (spk_b),
    .refractory_o (refr_b),
    .membrane_o   (mem_b),
    .spike_count_o(cnt_b)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: potential, cycles since last leak tick, refractory cycles still to show, spike tally.
  int m_v[2], m_phase[2], m_ref[2], m_cnt[2];
  bit m_spk[2];
  int thr[2] = '{64, 255};
  bit m_live = 1'b0;

  // Advance the model on every clock edge from the inputs presented to the DUTs.
  always @(posedge clk) begin
    int v;
    bit tick;
    for (int n = 0; n < 2; n++) begin
      if (!reset_i) begin
        m_v[n] = 0; m_phase[n] = 0; m_ref[n] = 0; m_cnt[n] = 0; m_spk[n] = 0;
      end else if (!en_i) begin
        m_spk[n] = 0;
      end else if (m_ref[n] > 0) begin
        m_ref[n] = m_ref[n] - 1;
        m_v[n] = 0; m_phase[n] = 0; m_spk[n] = 0;
      end else begin
        tick = (m_phase[n] == 15);
        m_phase[n] = tick ? 0 : m_phase[n] + 1;
        v = m_v[n];
        if (tick && v > 0) v = v - (((v / 8) > 0) ? (v / 8) : 1);
        if (excite_i) v = v + 16;
        if (inhibit_i) v = v - 8;
        if (v < 0) v = 0;
        if (v > 255) v = 255;
        if (v >= thr[n]) begin
          m_v[n] = 0; m_spk[n] = 1; m_ref[n] = 4; m_phase[n] = 0;
          m_cnt[n] = (m_cnt[n] < 255) ? m_cnt[n] + 1 : 255;
        end else begin
          m_v[n] = v; m_spk[n] = 0;
        end
      end
    end
    m_live = 1'b1;
  end

  // Compare both DUTs to the model on the falling edge of every cycle.
  always @(negedge clk) begin
    if (m_live) begin
      chk("a_spike", int'(spk_a), int'(m_spk[0]));
      chk("a_refr",  int'(refr_a), (m_ref[0] > 0) ? 1 : 0);
      chk("a_mem",   int'(mem_a), m_v[0]);
      chk("a_count", int'(cnt_a), m_cnt[0]);
      chk("b_spike", int'(spk_b), int'(m_spk[1]));
      chk("b_refr",  int'(refr_b), (m_ref[1] > 0) ? 1 : 0);
      chk("b_mem",   int'(mem_b), m_v[1]);
      chk("b_count", int'(cnt_b), m_cnt[1]);
    end
  end

  task automatic step(input bit rst, input bit en, input bit e, input bit i);
    @(negedge clk);
    reset_i = rst; en_i = en; excite_i = e; inhibit_i = i;
    @(posedge clk);
    #1;
  endtask

  int hi, spikes;

  initial begin
    // reset state
    step(0, 1, 0, 0); step(0, 1, 0, 0);
    chk("rst_mem", mem_a, 0); chk("rst_spike", spk_a, 0);
    chk("rst_refr", refr_a, 0); chk("rst_count", cnt_a, 0);

    // excites on alternate cycles build up to a spike
    step(1, 1, 1, 0); chk("exc1_mem", mem_a, 16);
    step(1, 1, 0, 0);
    step(1, 1, 1, 0); chk("exc2_mem", mem_a, 32);
    step(1, 1, 0, 0);
    step(1, 1, 1, 0); chk("exc3_mem", mem_a, 48);
    step(1, 1, 0, 0);
    step(1, 1, 1, 0);
    chk("fire_spike", spk_a, 1); chk("fire_mem", mem_a, 0);
    chk("fire_refr", refr_a, 1); chk("fire_count", cnt_a, 1);
    for (int k = 0; k < 3; k++) begin
      step(1, 1, 0, 0); chk("refr_hold", refr_a, 1); chk("spike_single", spk_a, 0);
    end
    step(1, 1, 0, 0); chk("refr_end", refr_a, 0);

    // floor at zero and simultaneous excite+inhibit
    step(0, 1, 0, 0);
    step(1, 1, 0, 1); chk("inh_floor", mem_a, 0);
    step(1, 1, 1, 1); chk("exc_inh_net", mem_a, 8);

    // leak from 48
    step(0, 1, 0, 0);
    for (int k = 0; k < 3; k++) step(1, 1, 1, 0);
    chk("leak_start", mem_a, 48);
    for (int c = 4; c <= 32; c++) begin
      step(1, 1, 0, 0);
      if (c == 16) chk("leak_tick1", mem_a, 42);
      if (c == 32) chk("leak_tick2", mem_a, 37);
    end

    // minimum leak of 1 down to 0
    step(0, 1, 0, 0);
    step(1, 1, 1, 1);
    for (int c = 2; c <= 144; c++) begin
      step(1, 1, 0, 0);
      if (c % 16 == 0) chk("leak_min", mem_a, (8 - c / 16 > 0) ? 8 - c / 16 : 0);
    end

    // inputs ignored during refractory, and en_i low stretches it
    step(0, 1, 0, 0);
    for (int k = 0; k < 4; k++) step(1, 1, 1, 0);
    chk("r_fire", spk_a, 1);
    hi = 1;
    for (int k = 0; k < 2; k++) begin
      step(1, 1, 1, 0);
      chk("r_ign_mem", mem_a, 0); chk("r_ign_spike", spk_a, 0); chk("r_ign_count", cnt_a, 1);
      if (refr_a) hi++;
    end
    for (int k = 0; k < 5; k++) begin
      step(1, 0, 1, 0);
      if (refr_a) hi++;
    end
    for (int k = 0; k < 20 && refr_a; k++) begin
      step(1, 1, 0, 0);
      if (refr_a) hi++;
    end
    chk("refr_stretched", hi, 9);

    // reset during refractory
    step(0, 1, 0, 0);
    for (int k = 0; k < 4; k++) step(1, 1, 1, 0);
    step(1, 1, 0, 0);
    step(0, 1, 0, 0);
    chk("midrst_refr", refr_a, 0); chk("midrst_count", cnt_a, 0);
    step(1, 1, 0, 0);
    chk("midrst_after", refr_a, 0);

    // upper clamp on the THRESHOLD=255 instance
    step(0, 1, 0, 0);
    for (int c = 1; c <= 16; c++) step(1, 1, 0, 0);
    for (int c = 17; c <= 31; c++) step(1, 1, 1, 0);
    chk("b_240", mem_b, 240);
    step(1, 1, 1, 0); chk("b_leak_exc", mem_b, 226);
    step(1, 1, 1, 0); chk("b_242", mem_b, 242);
    step(1, 1, 1, 0); chk("b_clamp_fire", spk_b, 1); chk("b_clamp_mem", mem_b, 0);

    // spike counter saturation
    step(0, 1, 0, 0);
    spikes = 0;
    for (int k = 0; k < 6000 && spikes < 300; k++) begin
      step(1, 1, 1, 0);
      if (spk_a) spikes++;
    end
    chk("spikes_seen", spikes, 300);
    chk("count_sat", cnt_a, 255);

    // randomized traffic against the model
    step(0, 1, 0, 0);
    for (int k = 0; k < 3000; k++) begin
      step($urandom_range(0, 99) != 0, $urandom_range(0, 9) != 0,
           $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0);
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
